// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned,
// start/busy/done handshake with cancel. Results are registered on FIX->DONE.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_op1,
  input  logic [WIDTH-1:0] div_op2,
  input  logic             div_cancel,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   part_q, part_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             s1_q, s1_d, s2_q, s2_d, zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   shifted, trial;

  // The partial remainder is always below the divisor, so a 33-bit trial
  // subtract gives a trustworthy sign bit.
  assign shifted = {part_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (div_start && !div_cancel) begin
          state_d = CALC;
          s1_d    = div_signed & div_op1[WIDTH-1];
          s2_d    = div_signed & div_op2[WIDTH-1];
          dvd_d   = s1_d ? -div_op1 : div_op1;
          dvs_d   = s2_d ? -div_op2 : div_op2;
          zero_d  = (div_op2 == '0);
          cnt_d   = '0;
          part_d  = '0;
        end
      end
      CALC: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else begin
          if (!trial[WIDTH]) begin
            part_d = trial;
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            part_d = shifted;
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          // With a zero divisor the remainder is |op1|; re-applying op1's sign
          // reproduces op1 bit-exactly, so only the quotient needs overriding.
          quot_d  = zero_q ? '1 : ((s1_q ^ s2_q) ? -dvd_q : dvd_q);
          rem_d   = s1_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
          dz_d    = zero_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign div_busy    = (state_q != IDLE);
  assign div_done    = (state_q == DONE);
  assign div_quot    = quot_q;
  assign div_rem     = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed + randomized bench for div_unit; expected results are queued at
// issue time and compared when div_done pulses.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset, div_start, div_signed, div_cancel;
  logic [31:0] div_op1, div_op2;
  logic        div_busy, div_done, div_by_zero;
  logic [31:0] div_quot, div_rem;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .div_start(div_start), .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2), .div_cancel(div_cancel),
    .div_busy(div_busy), .div_done(div_done), .div_quot(div_quot),
    .div_rem(div_rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errs = 0, checks = 0;
  int          cyc = 0;
  logic [31:0] last_q = 0, last_r = 0;
  logic        last_dz = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.cyc = 0;
    e.dz  = 1'b0;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 0;
    end else if (sg) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Scoreboard side: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!reset && div_done) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", div_quot, e.q);
        chk("rem", div_rem, e.r);
        chk("dz", 32'(div_by_zero), 32'(e.dz));
        chk("latency", cyc, e.cyc);
        last_q = e.q; last_r = e.r; last_dz = e.dz;
      end
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (div_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Drives one start at a negedge; returns just after the accept edge.
  task automatic issue(input bit sg, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (div_busy && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    div_start = 1; div_signed = sg; div_op1 = a; div_op2 = b;
    if (push) begin
      e = model(sg, a, b);
      e.cyc = cyc + 1 + 33;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 div_start = 0;
  endtask

  task automatic run(input bit sg, input logic [31:0] a, input logic [31:0] b);
    int n;
    issue(sg, a, b, 1);
    wait_idle(n);
    chk("busy_len", n, 34);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_busy"}, 32'(div_busy), 32'd0);
    chk({tag, "_quot"}, div_quot, last_q);
    chk({tag, "_rem"}, div_rem, last_r);
    chk({tag, "_dz"}, 32'(div_by_zero), 32'(last_dz));
  endtask

  initial begin
    int n;
    bit sg;
    logic [31:0] a, b;

    reset = 1; div_start = 0; div_signed = 0; div_cancel = 0;
    div_op1 = 0; div_op2 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_done", 32'(div_done), 32'd0);
    chk("rst_quot", div_quot, 32'd0);
    chk("rst_rem", div_rem, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);

    run(0, 32'd100, 32'd7);
    run(1, -32'sd7, 32'd2);
    run(1, 32'd7, -32'sd2);
    run(1, -32'sd7, -32'sd2);
    run(1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(0, 32'hFFFF_FFFF, 32'd1);
    run(1, 32'h1234_5678, 32'd0);
    run(0, 32'h8765_4321, 32'd0);
    run(1, 32'h8000_0000, 32'd0);
    run(0, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start with different operands during CALC must be ignored.
    issue(0, 32'd1000, 32'd33, 1);
    repeat (5) @(negedge clk);
    div_start = 1; div_signed = 1; div_op1 = 32'd5; div_op2 = 32'd1;
    @(posedge clk);
    #1 div_start = 0;
    wait_idle(n);
    repeat (3) @(negedge clk);
    chk("ign_busy", 32'(div_busy), 32'd0);
    chk("ign_sb", sb.size(), 32'd0);

    // Cancel mid-CALC: back to idle, previous result held, then restart.
    issue(0, 32'd999, 32'd10, 0);
    repeat (10) @(negedge clk);
    div_cancel = 1;
    @(posedge clk);
    #1 div_cancel = 0;
    chk_held("cancel");
    run(1, -32'sd100, 32'd7);

    // Cancel wins over a coincident start in IDLE.
    @(negedge clk);
    div_start = 1; div_cancel = 1; div_op1 = 32'd50; div_op2 = 32'd5;
    @(posedge clk);
    #1 begin div_start = 0; div_cancel = 0; end
    chk_held("idle_cancel");

    // Reset mid-CALC clears outputs.
    issue(1, 32'd12345, 32'd17, 0);
    repeat (20) @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    last_q = 0; last_r = 0; last_dz = 0;
    chk_held("rst_mid");
    chk("rst_mid_done", 32'(div_done), 32'd0);
    run(0, 32'd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 2))
        0: b = $urandom;
        1: b = $urandom_range(1, 50);
        default: b = -$urandom_range(1, 50);
      endcase
      if (i % 13 == 12) b = 0;
      if (i % 6 == 5) begin
        issue(sg, a, b, 0);
        repeat ($urandom_range(1, 32)) @(negedge clk);
        div_cancel = 1; div_start = 1;
        @(posedge clk);
        #1 begin div_cancel = 0; div_start = 0; end
        chk_held("rnd_cancel");
      end else begin
        run(sg, a, b);
      end
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the execute stage, serving the signed and unsigned divide instructions that the single-cycle ALU does not implement. It accepts one operation at a time through a start/busy/done handshake and computes one quotient bit per cycle by restoring shift-subtract. It produces a 32-bit quotient and a 32-bit remainder for the HI/LO write-back path. The pipeline stalls on `div_busy` and captures results on the single-cycle `div_done` pulse.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. The iteration count equals `WIDTH`. Only 32 is verified.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `div_start`  in  1  request. Sampled only in IDLE.
- `div_signed`  in  1  1 selects signed division (div), 0 selects unsigned (divu). Sampled with `div_start`.
- `div_op1`  in  32  dividend. Sampled with `div_start`.
- `div_op2`  in  32  divisor. Sampled with `div_start`.
- `div_cancel`  in  1  abort, e.g. on an exception flush.
- `div_busy`  out  1  high whenever state is not IDLE.
- `div_done`  out  1  one-cycle pulse; results are valid during this cycle.
- `div_quot`  out  32  quotient (LO). Registered.
- `div_rem`  out  32  remainder (HI). Registered.
- `div_by_zero`  out  1  registered flag; high when the completed operation had `div_op2`=0.

## Operation
- States:
  - IDLE → CALC when `div_start`=1 and `div_cancel`=0.
  - CALC → FIX after the 32nd iteration.
  - FIX → DONE.
  - DONE → IDLE.
- On accept:
  - Latch sign flags: `s1`=op1[31]&signed, `s2`=op2[31]&signed.
  - Latch absolute values |op1| and |op2| as 32-bit unsigned. 0x80000000 stays 0x80000000.
  - Clear the 6-bit iteration counter and the 33-bit partial remainder.
- CALC, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial = partial remainder − divisor, computed 33 bits wide.
  - If the trial is non-negative, keep it and shift in quotient bit 1; otherwise keep the old value and shift in 0.
  - Increment the counter. Leave CALC when the counter reaches 31 as the iteration completes.
- FIX, applied when writing `div_quot`/`div_rem`/`div_by_zero`:
  - Quotient is negated iff `s1`^`s2`.
  - Remainder is negated iff `s1`. The remainder takes the dividend's sign, and truncation is toward zero.
  - Negation is two's complement mod 2^32.
- Divide by zero:
  - Full latency is kept.
  - `div_quot`=0xFFFFFFFF and `div_rem`=`div_op1` as sampled, for both signed and unsigned.
  - `div_by_zero`=1. Sign fix is not applied.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives `div_quot`=0x80000000 and `div_rem`=0. This is not flagged.
- `div_start` while busy is ignored. The in-flight operation and its operands are unaffected.
- `div_cancel`:
  - In any non-IDLE state, returns to IDLE on the next edge.
  - `div_done` is not pulsed. `div_quot`/`div_rem`/`div_by_zero` keep their previous values.
  - In IDLE, cancel blocks a coincident start; cancel wins.
- Cancel during DONE: `div_done` is already high for that cycle. The cycle is still a valid completion, and the next state is IDLE either way.
- Outputs `div_quot`/`div_rem`/`div_by_zero` change only in FIX→DONE and on reset. They hold until the next completed operation.

## Timing
- Reset values:
  - state IDLE
  - `div_busy`=0, `div_done`=0
  - `div_quot`=0, `div_rem`=0, `div_by_zero`=0
  - counter 0
- Reset has priority over start and cancel, in any state, including mid-CALC.
- Let edge E be the edge that accepts `div_start`:
  - `div_busy`=1 from E until E+34.
  - CALC occupies the cycles after E+1 through E+32.
  - FIX occupies the cycle after E+32.
  - Results register at edge E+33, and `div_done`=1 for the one cycle E+33..E+34.
  - `div_busy` falls at E+34.
- Fixed latency is 33 cycles from the accept edge to `div_done`. It is independent of operand values.
- Back-to-back: a new `div_start` can be accepted at edge E+34 at the earliest, i.e. when `div_busy`=0.
- No combinational path from any input to any output.

## Test plan
- Unsigned 100/7: `div_signed`=0, op1=100, op2=7 → after 33 cycles, `div_done` pulses once with `div_quot`=14, `div_rem`=2, `div_by_zero`=0. `div_busy` is high for exactly 34 cycles.
- Signed sign rules:
  - −7/2 → quot 0xFFFFFFFD, rem 0xFFFFFFFF.
  - 7/−2 → quot 0xFFFFFFFD, rem 1.
  - 0x80000000/0xFFFFFFFF → quot 0x80000000, rem 0.
  - Unsigned 0xFFFFFFFF/1 → quot 0xFFFFFFFF, rem 0.
- Divide by zero: signed 0x12345678/0 → quot 0xFFFFFFFF, rem 0x12345678, `div_by_zero`=1, with the same 33-cycle latency.
- Handshake:
  - A `div_start` with different operands at cycle 5 of CALC is ignored, and the first result is unchanged.
  - `div_cancel` at CALC cycle 10 → `div_busy`=0 on the next edge, no `div_done`, and outputs keep the prior result.
  - An immediate restart completes correctly.
- Reset mid-CALC, asserted one cycle at cycle 20 → next edge: `div_busy`=0, `div_quot`=`div_rem`=0, no `div_done`. A subsequent 100/7 then yields 14/2.
- Randomized signed and unsigned operands against a reference model. Cover quot/rem equivalence with C truncating `/` and `%`, all four sign combinations, and cancel/start collisions.
